// File: rtl/riscv_immgen_stage.sv
// RISC-V immediate-generation stage: decodes and sign-extends the immediate of one
// instruction per handshake and holds results in a 2-entry registered skid buffer.
module riscv_immgen_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TAG_W      = 8,
  parameter bit          CSR_IMM_EN = 1'b1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Flush,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [31:0]      i_Inst,
  input  logic [TAG_W-1:0] i_Tag,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [XLEN-1:0]  o_Immediate,
  output logic [2:0]       o_ImmType,
  output logic             o_Unknown,
  output logic [TAG_W-1:0] o_Tag
);

  localparam bit IS_RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_type_e        typ;
    logic             unknown;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [6:0]  w_opcode;
  logic        w_sign;
  imm_type_e   w_type;
  logic        w_unknown;
  logic [31:0] w_imm32;
  logic [XLEN-1:0] w_imm;
  entry_t      w_in;
  logic        w_unused;

  state_e r_state;
  state_e w_state_nxt;
  logic   r_valid;
  logic   r_ready;
  entry_t r_m;
  entry_t r_k;

  logic w_accept;
  logic w_pop;
  logic w_ld_m_in;
  logic w_ld_m_k;
  logic w_ld_k_in;
  logic w_clr_m;
  logic w_clr_k;

  assign w_opcode = i_Inst[6:0];
  assign w_sign   = i_Inst[31];
  assign w_unused = ^i_Inst[13:12];

  // Format classification from the opcode
  always_comb begin
    w_type    = IMM_NONE;
    w_unknown = 1'b0;
    case (w_opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: w_type = IMM_I;
      OPC_OP_IMM_32: begin
        if (IS_RV64) w_type = IMM_I;
        else         w_unknown = 1'b1;
      end
      OPC_STORE:           w_type = IMM_S;
      OPC_BRANCH:          w_type = IMM_B;
      OPC_LUI, OPC_AUIPC:  w_type = IMM_U;
      OPC_JAL:             w_type = IMM_J;
      OPC_SYSTEM: begin
        if (CSR_IMM_EN && i_Inst[14]) w_type = IMM_Z;
      end
      OPC_OP, OPC_MISC_MEM: w_type = IMM_NONE;
      OPC_OP_32: begin
        if (!IS_RV64) w_unknown = 1'b1;
      end
      default: w_unknown = 1'b1;
    endcase
  end

  // Every format fits a 32-bit value whose bit 31 is the correct sign for XLEN
  always_comb begin
    w_imm32 = '0;
    case (w_type)
      IMM_I: w_imm32 = {{20{w_sign}}, i_Inst[31:20]};
      IMM_S: w_imm32 = {{20{w_sign}}, i_Inst[31:25], i_Inst[11:7]};
      IMM_B: w_imm32 = {{20{w_sign}}, i_Inst[7], i_Inst[30:25], i_Inst[11:8], 1'b0};
      IMM_U: w_imm32 = {i_Inst[31:12], 12'h000};
      IMM_J: w_imm32 = {{12{w_sign}}, i_Inst[19:12], i_Inst[20], i_Inst[30:21], 1'b0};
      IMM_Z: w_imm32 = {27'd0, i_Inst[19:15]};
      default: w_imm32 = '0;
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  always_comb begin
    w_in         = '0;
    w_in.imm     = w_imm;
    w_in.typ     = w_type;
    w_in.unknown = w_unknown;
    w_in.tag     = i_Tag;
  end

  assign w_accept = i_Valid & r_ready;
  assign w_pop    = r_valid & i_Ready;

  // Occupancy FSM; flush wins over accept and pop
  always_comb begin
    w_state_nxt = r_state;
    w_ld_m_in   = 1'b0;
    w_ld_m_k    = 1'b0;
    w_ld_k_in   = 1'b0;
    w_clr_m     = 1'b0;
    w_clr_k     = 1'b0;
    if (i_Flush) begin
      w_state_nxt = ST_EMPTY;
      w_clr_m     = 1'b1;
      w_clr_k     = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_ld_m_in   = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            w_ld_m_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_ld_k_in   = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
            w_clr_m     = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_state_nxt = ST_ONE;
            w_ld_m_k    = 1'b1;
            w_clr_k     = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_clr_m     = 1'b1;
          w_clr_k     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt != ST_EMPTY);
      r_ready <= (w_state_nxt != ST_FULL);
    end
  end

  // Entries are zeroed whenever they become invalid
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_m <= '0;
      r_k <= '0;
    end else begin
      if (w_clr_m)        r_m <= '0;
      else if (w_ld_m_in) r_m <= w_in;
      else if (w_ld_m_k)  r_m <= r_k;

      if (w_clr_k)        r_k <= '0;
      else if (w_ld_k_in) r_k <= w_in;
    end
  end

  assign o_Ready     = r_ready;
  assign o_Valid     = r_valid;
  assign o_Immediate = r_m.imm;
  assign o_ImmType   = r_m.typ;
  assign o_Unknown   = r_m.unknown;
  assign o_Tag       = r_m.tag;

endmodule

// File: tb/tb_riscv_immgen_stage.sv
// Scoreboard bench for riscv_immgen_stage: RV32, RV64 and CSR-immediate-disabled instances.
module tb_riscv_immgen_stage;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_Z    = 3'd6;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        unk;
    logic [7:0]  tag;
    bit          lat;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;
  logic flush = 1'b0;
  logic [2:0]  vld = 3'b000;
  logic [31:0] inst_v [3];
  logic [7:0]  tag_v  [3];
  logic [2:0]  ordy;
  logic [2:0]  ov;
  logic [2:0]  ounk;
  logic [2:0]  otyp [3];
  logic [7:0]  otag [3];
  logic [31:0] imm_a;
  logic [63:0] imm_b;
  logic [31:0] imm_c;
  logic [63:0] oimm [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign oimm[0] = {32'h0, imm_a};
  assign oimm[1] = imm_b;
  assign oimm[2] = {32'h0, imm_c};

  riscv_immgen_stage #(.XLEN(32), .TAG_W(8), .CSR_IMM_EN(1'b1)) u_dut32 (
    .i_Clk(clk), .i_Rst(rst), .i_Flush(flush), .i_Valid(vld[0]), .o_Ready(ordy[0]),
    .i_Inst(inst_v[0]), .i_Tag(tag_v[0]), .o_Valid(ov[0]), .i_Ready(rdy),
    .o_Immediate(imm_a), .o_ImmType(otyp[0]), .o_Unknown(ounk[0]), .o_Tag(otag[0]));

  riscv_immgen_stage #(.XLEN(64), .TAG_W(8), .CSR_IMM_EN(1'b1)) u_dut64 (
    .i_Clk(clk), .i_Rst(rst), .i_Flush(flush), .i_Valid(vld[1]), .o_Ready(ordy[1]),
    .i_Inst(inst_v[1]), .i_Tag(tag_v[1]), .o_Valid(ov[1]), .i_Ready(rdy),
    .o_Immediate(imm_b), .o_ImmType(otyp[1]), .o_Unknown(ounk[1]), .o_Tag(otag[1]));

  riscv_immgen_stage #(.XLEN(32), .TAG_W(8), .CSR_IMM_EN(1'b0)) u_dutnz (
    .i_Clk(clk), .i_Rst(rst), .i_Flush(flush), .i_Valid(vld[2]), .o_Ready(ordy[2]),
    .i_Inst(inst_v[2]), .i_Tag(tag_v[2]), .o_Valid(ov[2]), .i_Ready(rdy),
    .o_Immediate(imm_c), .o_ImmType(otyp[2]), .o_Unknown(ounk[2]), .o_Tag(otag[2]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_check(input int d);
    exp_t e;
    bit   have = 1'b0;
    case (d)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    n_tests++;
    if (!have) begin
      n_fail++;
      $display("FAIL unexpected_output dut%0d: imm=%h tag=%h", d, oimm[d], otag[d]);
      return;
    end
    if (oimm[d] !== e.imm || otyp[d] !== e.typ || ounk[d] !== e.unk ||
        otag[d] !== e.tag || (e.lat && cyc != e.cyc + 1)) begin
      n_fail++;
      $display("FAIL pop dut%0d: got imm=%h type=%0d unk=%b tag=%h cyc=%0d expected imm=%h type=%0d unk=%b tag=%h cyc=%0d",
               d, oimm[d], otyp[d], ounk[d], otag[d], cyc, e.imm, e.typ, e.unk, e.tag, e.cyc + 1);
    end
  endtask

  // Monitor: an entry is consumed whenever valid and ready meet at the next edge
  always @(negedge clk) begin
    if (!rst && rdy) begin
      for (int d = 0; d < 3; d++) if (ov[d]) pop_check(d);
    end
  end

  task automatic send(input int d, input logic [31:0] ins, input logic [7:0] tg,
                      input logic [63:0] imm, input logic [2:0] typ, input logic unk,
                      input bit lat);
    exp_t e;
    vld[d]    = 1'b1;
    inst_v[d] = ins;
    tag_v[d]  = tg;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ordy[d]) begin
        e.imm = imm; e.typ = typ; e.unk = unk; e.tag = tg; e.lat = lat; e.cyc = cyc;
        case (d)
          0: q0.push_back(e);
          1: q1.push_back(e);
          default: q2.push_back(e);
        endcase
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    n_tests++;
    n_fail++;
    $display("FAIL send_timeout dut%0d: inst %h never accepted", d, ins);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_q", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int d = 0; d < 3; d++) begin inst_v[d] = '0; tag_v[d] = '0; end
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", 64'(ov[0]), 64'd0);
    chk("rst_ready", 64'(ordy[0]), 64'd1);
    chk("rst_imm", oimm[0], 64'd0);
    chk("rst_type", 64'(otyp[0]), 64'd0);
    chk("rst_unk", 64'(ounk[0]), 64'd0);
    chk("rst_tag", 64'(otag[0]), 64'd0);
    chk("rst_imm64", oimm[1], 64'd0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back stream, one-cycle latency, full throughput
    rdy = 1'b1;
    c0 = cyc;
    send(0, 32'hFFF00093, 8'd1, 64'hFFFFFFFF, T_I, 1'b0, 1'b1);
    send(0, 32'hFE000EE3, 8'd2, 64'hFFFFFFFC, T_B, 1'b0, 1'b1);
    send(0, 32'h001000EF, 8'd3, 64'h00000800, T_J, 1'b0, 1'b1);
    send(0, 32'h000FD073, 8'd4, 64'h0000001F, T_Z, 1'b0, 1'b1);
    chk("stream_cycles", 64'(cyc - c0), 64'd4);
    chk("stream_ready", 64'(ordy[0]), 64'd1);
    send(0, 32'hFE112E23, 8'd5, 64'hFFFFFFFC, T_S, 1'b0, 1'b1);
    send(0, 32'h12345017, 8'd6, 64'h12345000, T_U, 1'b0, 1'b1);
    send(0, 32'h800000B7, 8'd7, 64'h80000000, T_U, 1'b0, 1'b1);
    send(0, 32'h00812083, 8'd8, 64'h00000008, T_I, 1'b0, 1'b1);
    send(0, 32'h00008067, 8'd9, 64'h00000000, T_I, 1'b0, 1'b1);
    send(0, 32'h0000007F, 8'd10, 64'h0, T_NONE, 1'b1, 1'b1);
    send(0, 32'h002081B3, 8'd11, 64'h0, T_NONE, 1'b0, 1'b1);
    send(0, 32'hFFF0009B, 8'd12, 64'h0, T_NONE, 1'b1, 1'b1);
    send(0, 32'h0000003B, 8'd13, 64'h0, T_NONE, 1'b1, 1'b1);
    send(0, 32'h0000000F, 8'd14, 64'h0, T_NONE, 1'b0, 1'b1);
    send(0, 32'h30001073, 8'd15, 64'h0, T_NONE, 1'b0, 1'b1);
    vld[0] = 1'b0;

    send(1, 32'h800000B7, 8'h41, 64'hFFFFFFFF80000000, T_U, 1'b0, 1'b1);
    send(1, 32'hFFF0009B, 8'h42, 64'hFFFFFFFFFFFFFFFF, T_I, 1'b0, 1'b1);
    send(1, 32'h0000003B, 8'h43, 64'h0, T_NONE, 1'b0, 1'b1);
    send(1, 32'hFE112E23, 8'h44, 64'hFFFFFFFFFFFFFFFC, T_S, 1'b0, 1'b1);
    send(1, 32'h001000EF, 8'h45, 64'h0000000000000800, T_J, 1'b0, 1'b1);
    send(1, 32'h0000007F, 8'h46, 64'h0, T_NONE, 1'b1, 1'b1);
    send(1, 32'h000FD073, 8'h47, 64'h1F, T_Z, 1'b0, 1'b1);
    vld[1] = 1'b0;

    send(2, 32'h000FD073, 8'h81, 64'h0, T_NONE, 1'b0, 1'b1);
    send(2, 32'hFFF00093, 8'h82, 64'hFFFFFFFF, T_I, 1'b0, 1'b1);
    send(2, 32'h30001073, 8'h83, 64'h0, T_NONE, 1'b0, 1'b1);
    vld[2] = 1'b0;
    wait_empty();

    // Backpressure: two accepted, third stalls while outputs hold the first
    rdy = 1'b0;
    send(0, 32'h00500093, 8'h10, 64'h00000005, T_I, 1'b0, 1'b0);
    send(0, 32'h7FF00093, 8'h11, 64'h000007FF, T_I, 1'b0, 1'b0);
    chk("bp_ready_fall", 64'(ordy[0]), 64'd0);
    inst_v[0] = 32'h80000093;
    tag_v[0]  = 8'h12;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hold_valid", 64'(ov[0]), 64'd1);
    chk("bp_hold_tag", 64'(otag[0]), 64'h10);
    chk("bp_hold_imm", oimm[0], 64'h5);
    chk("bp_still_full", 64'(ordy[0]), 64'd0);
    rdy = 1'b1;
    send(0, 32'h80000093, 8'h12, 64'hFFFFF800, T_I, 1'b0, 1'b0);
    vld[0] = 1'b0;
    wait_empty();
    @(posedge clk); #1;
    chk("bp_ready_back", 64'(ordy[0]), 64'd1);
    chk("idle_valid", 64'(ov[0]), 64'd0);
    chk("idle_imm_zero", oimm[0], 64'd0);
    chk("idle_tag_zero", 64'(otag[0]), 64'd0);

    // Flush while FULL with a pending input
    rdy = 1'b0;
    send(0, 32'h00100093, 8'h20, 64'h1, T_I, 1'b0, 1'b0);
    send(0, 32'h00200093, 8'h21, 64'h2, T_I, 1'b0, 1'b0);
    inst_v[0] = 32'h00300093;
    tag_v[0]  = 8'h22;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vld[0] = 1'b0;
    q0.delete();
    chk("flush_full_valid", 64'(ov[0]), 64'd0);
    chk("flush_full_ready", 64'(ordy[0]), 64'd1);
    chk("flush_full_imm", oimm[0], 64'd0);
    @(posedge clk); #1;
    chk("flush_full_nothing", 64'(ov[0]), 64'd0);

    // Flush in ONE state while an accept is possible: the accept is discarded
    send(0, 32'h00400093, 8'h23, 64'h4, T_I, 1'b0, 1'b0);
    inst_v[0] = 32'h00500093;
    tag_v[0]  = 8'h24;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vld[0] = 1'b0;
    q0.delete();
    chk("flush_one_valid", 64'(ov[0]), 64'd0);
    chk("flush_one_ready", 64'(ordy[0]), 64'd1);
    @(posedge clk); #1;
    chk("flush_one_dropped", 64'(ov[0]), 64'd0);

    // Asynchronous reset between clock edges
    send(0, 32'h00600093, 8'h30, 64'h6, T_I, 1'b0, 1'b0);
    send(0, 32'h00700093, 8'h31, 64'h7, T_I, 1'b0, 1'b0);
    vld[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    q0.delete();
    chk("arst_valid", 64'(ov[0]), 64'd0);
    chk("arst_imm", oimm[0], 64'd0);
    chk("arst_tag", 64'(otag[0]), 64'd0);
    chk("arst_ready", 64'(ordy[0]), 64'd1);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    rdy = 1'b1;
    send(0, 32'hFFF00093, 8'h33, 64'hFFFFFFFF, T_I, 1'b0, 1'b1);
    vld[0] = 1'b0;
    wait_empty();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
